// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter sharing one mesh output link; one-entry registered output, 1-cycle accept->out_valid.
// Backpressure: while out_valid && !out_ready the flit is held and req_ready stays low.

package parameters;
  localparam int NUM_PORTS = 5;
endpackage

package types;
  typedef enum logic [2:0] {
    CTRL_DATA   = 3'd0,
    CTRL_CONFIG = 3'd1,
    CTRL_READ   = 3'd2,
    CTRL_WRITE  = 3'd3,
    CTRL_ACK    = 3'd4,
    CTRL_NACK   = 3'd5,
    CTRL_IRQ    = 3'd6,
    CTRL_RSVD   = 3'd7
  } ctrl_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
  } addr_t;

  typedef struct packed {
    ctrl_t       ctrl;
    addr_t       addr;
    logic [39:0] data;
  } pkt_t;
endpackage

module noc_port_arbiter #(
  parameter int N_REQ = parameters::NUM_PORTS,
  parameter int PKT_W = $bits(types::pkt_t),
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*PKT_W-1:0]   req_pkt,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [PKT_W-1:0]         out_pkt,
  input  logic                     out_ready,
  output logic [$clog2(N_REQ)-1:0] last_grant,
  output logic [CNT_W-1:0]         fwd_count
);

  localparam int IDX_W = $clog2(N_REQ);

  logic             can_load;
  logic             any_req;
  logic             grant_en;
  logic             drain;
  logic [IDX_W-1:0] winner;

  assign can_load = !out_valid || out_ready;
  assign any_req  = |req_valid;
  assign drain    = out_valid && out_ready;
  // rst_n gating keeps req_ready low for the whole reset window, not just after the first edge.
  assign grant_en = any_req && can_load && rst_n;

  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && req_valid[IDX_W'(idx)]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = grant_en && (winner == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pkt    <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
    end else if (grant_en) begin
      out_valid  <= 1'b1;
      out_pkt    <= req_pkt[winner*PKT_W +: PKT_W];
      last_grant <= winner;
    end else if (drain) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count <= '0;
    end else if (drain && (fwd_count != {CNT_W{1'b1}})) begin
      fwd_count <= fwd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed and random stimulus for noc_port_arbiter against a queue-free transaction-level model.
module tb_noc_port_arbiter;
  import types::*;

  localparam int N     = 5;
  localparam int PKT_W = $bits(pkt_t);
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N*PKT_W-1:0]   req_pkt;
  logic [N-1:0]         req_ready;
  logic                 out_valid;
  logic [PKT_W-1:0]     out_pkt;
  logic                 out_ready;
  logic [2:0]           last_grant;
  logic [CNT_W-1:0]     fwd_count;

  noc_port_arbiter #(.N_REQ(N), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pkt(req_pkt),
    .req_ready(req_ready), .out_valid(out_valid), .out_pkt(out_pkt),
    .out_ready(out_ready), .last_grant(last_grant), .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;

  // Reference model state: what the link should be holding, and who was served last.
  int   m_ptr;
  bit   m_valid;
  pkt_t m_pkt;
  int   m_cnt;
  int   last_win;
  bit   use_ovr = 0;
  pkt_t ovr;
  pkt_t saved;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.ctrl   = ctrl_t'($urandom_range(0, 7));
    p.addr.x = 4'($urandom);
    p.addr.y = 4'($urandom);
    p.addr.z = 4'($urandom);
    p.data   = 40'({$urandom, $urandom});
    return p;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1; m_valid = 0; m_pkt = '0; m_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".out_pkt"}, 64'(out_pkt), 64'd0);
    chk({tag, ".last_grant"}, 64'(last_grant), 64'(N - 1));
    chk({tag, ".fwd_count"}, 64'(fwd_count), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '1; out_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive at negedge, check the combinational grant, clock, check registered state.
  task automatic step(input logic [N-1:0] v, input logic ordy);
    pkt_t   pk [N];
    logic [N-1:0] exp_rdy;
    int     win;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      pk[i] = (use_ovr && i == 0) ? ovr : rand_pkt();
      req_pkt[i*PKT_W +: PKT_W] = pk[i];
    end
    req_valid = v; out_ready = ordy;
    #1;
    win = -1;
    exp_rdy = '0;
    if ((!m_valid || ordy) && v != 0) begin
      for (int k = 1; k <= N; k++) begin
        if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      exp_rdy[win] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (m_valid && ordy && m_cnt < CMAX) m_cnt++;
    if (win >= 0) begin
      m_pkt = pk[win]; m_valid = 1; m_ptr = win;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    last_win = win;
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) chk("out_pkt", 64'(out_pkt), 64'(m_pkt));
    chk("last_grant", 64'(last_grant), 64'(m_ptr));
    chk("fwd_count", 64'(fwd_count), 64'(m_cnt));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_pkt = '0; out_ready = 1'b0;
    model_reset();

    // Single flit on input 0, field pass-through.
    do_reset();
    ovr.ctrl = CTRL_CONFIG; ovr.addr.x = 4'd1; ovr.addr.y = 4'd2; ovr.addr.z = 4'd3;
    ovr.data = 40'h12_3456_789A;
    use_ovr = 1;
    step(5'b00001, 1'b1);
    use_ovr = 0;
    chk("t1.grant0", 64'(last_win), 64'd0);
    chk("t1.pkt", 64'(out_pkt), 64'(ovr));
    step(5'b00000, 1'b1);
    chk("t1.count", 64'(fwd_count), 64'd1);

    // All five requesting: strict rotation at full throughput.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(5'b11111, 1'b1);
      chk("t2.order", 64'(last_grant), 64'(i % N));
      chk("t2.valid", 64'(out_valid), 64'd1);
    end
    step(5'b00000, 1'b1);
    chk("t2.count", 64'(fwd_count), 64'd10);

    // Stall with inputs 1 and 3 pending, then drain-and-load in one cycle.
    do_reset();
    step(5'b01010, 1'b0);
    chk("t3.first", 64'(last_win), 64'd1);
    saved = pkt_t'(out_pkt);
    for (int i = 0; i < 3; i++) begin
      step(5'b01010, 1'b0);
      chk("t3.stall_rdy", 64'(last_win), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t3.stable", 64'(out_pkt), 64'(saved));
    end
    step(5'b01010, 1'b1);
    chk("t3.next", 64'(last_grant), 64'd3);
    chk("t3.count", 64'(fwd_count), 64'd1);

    // Wrap-around search from pointer 2.
    do_reset();
    step(5'b00100, 1'b1);
    step(5'b00011, 1'b1);
    chk("t4.wrap0", 64'(last_grant), 64'd0);
    step(5'b00011, 1'b1);
    chk("t4.then1", 64'(last_grant), 64'd1);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < CMAX + 6; i++) step(5'b11111, 1'b1);
    step(5'b00000, 1'b1);
    chk("t5.sat", 64'(fwd_count), 64'(CMAX));
    step(5'b00000, 1'b1);
    chk("t5.hold", 64'(fwd_count), 64'(CMAX));

    // Asynchronous reset while a flit is stalled.
    do_reset();
    step(5'b00010, 1'b0);
    step(5'b00010, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6.async");
    req_valid = '0;
    #3;
    rst_n = 1'b1;
    model_reset();
    step(5'b00011, 1'b1);
    chk("t6.first", 64'(last_grant), 64'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Shares one mesh output link (N/S/E/W or LOCAL) between the NUM_PORTS router inputs that target it. Each request carries a single-flit types::pkt_t.
- Uses a work-conserving round-robin grant into a one-entry registered output stage with a valid/ready handshake.
- Instantiated NUM_PORTS times per router, one per output direction, downstream of the XY route compute.
- Keeps a saturating forwarded-packet counter for debug and performance.

Parameters:
- N_REQ, default parameters::NUM_PORTS (5): number of requesters; bit i = input port i (NORTH=0 .. LOCAL=4).
- PKT_W, default $bits(types::pkt_t) (55): flit width.
- CNT_W, default 16: width of the forwarded-packet counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-input request; bit i means input i holds a flit for this output
- req_pkt  in  N_REQ*PKT_W  flits, input i at [i*PKT_W +: PKT_W]
- req_ready  out  N_REQ  one-hot-or-zero; bit i high means input i's flit is consumed this cycle
- out_valid  out  1  output register holds a flit
- out_pkt  out  PKT_W  registered flit
- out_ready  in  1  downstream accepts the flit
- last_grant  out  $clog2(N_REQ)  index of the most recent grant (round-robin pointer)
- fwd_count  out  CNT_W  number of flits accepted by downstream, saturating

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - out_valid=0, out_pkt=0, last_grant=N_REQ-1, so input 0 has first priority.
  - fwd_count=0; req_ready=0 while rst_n low.
- can_load = !out_valid || out_ready.
- Grant is combinational and round-robin:
  - Search starts at (last_grant+1) mod N_REQ and wraps.
  - The first i with req_valid[i] wins.
  - req_ready[i] = (i==winner) && can_load && |req_valid. At most one bit is high.
- On a cycle with req_ready[i]:
  - out_pkt <= slice i, out_valid <= 1, last_grant <= i.
  - Latency is one cycle from accept to out_valid.
- On a cycle with out_valid && out_ready and no grant: out_valid <= 0, and out_pkt holds its last value.
- Simultaneous drain and grant (out_valid && out_ready && any req_valid): the new flit loads in the same cycle, so the link sustains full throughput of one flit per cycle.
- Backpressure: while out_valid && !out_ready, out_pkt and out_valid are held stable, and req_ready=0 regardless of requests.
- The pointer advances only on a grant. Idle cycles and stalled cycles leave last_grant unchanged.
- Fairness bound: a continuously valid requester is granted within N_REQ grants.
- fwd_count increments by 1 on every out_valid && out_ready and holds at 2^CNT_W-1.
- Packets are never reordered, dropped or modified. The ctrl, addr and data fields pass through bit-exact.
- Requesters must hold req_valid and req_pkt stable until req_ready. The arbiter does not depend on this, but a requester that withdraws req_valid loses its turn only if no grant was issued.
- Reset asserted mid-transfer: any held flit is discarded, out_valid drops immediately (asynchronously), and the pointer returns to N_REQ-1.
- No combinational path from out_ready to out_pkt. There is a combinational path from out_ready and req_valid to req_ready.

Test Plan:
- Reset, then req_valid=5'b00001 with pkt ctrl=CTRL_CONFIG, addr={x=1,y=2,z=3}, out_ready=1.
  - req_ready=5'b00001 in cycle 0; out_valid=1 with an identical pkt in cycle 1; fwd_count=1 in cycle 2.
- All five inputs valid continuously with out_ready=1 for 10 cycles.
  - Grant order is 0,1,2,3,4,0,1,2,3,4, one per cycle; out_valid stays 1; fwd_count=10.
- Hold out_ready=0 for 4 cycles with inputs 1 and 3 valid.
  - One grant to 1, then req_ready=0 for 3 cycles with out_pkt stable.
  - On out_ready=1, input 3 is granted in the same cycle the flit from 1 drains.
- last_grant=2, req_valid=5'b00011.
  - Grant goes to 0 (the search wraps past 4), then 1; last_grant becomes 0, then 1.
- Preload fwd_count to 16'hFFFE via 2 extra transfers after forcing near-saturation (or set CNT_W=2 and send 5 flits).
  - fwd_count=3 and stays at 3.
- Pulse rst_n low for half a cycle while out_valid=1 and out_ready=0.
  - out_valid=0 immediately; after release the first grant goes to input 0, not to the stalled requester's successor.
